// File: rtl/inst_fetch_if.sv
// Fetch-side bus: program write port plus the IR valid/ready handshake
// towards the execute/flag stage.
interface inst_fetch_if #(
   parameter int ADDR_W = 4
);
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [31:0]       prog_data;
   logic [31:0]       ir_out;
   logic              ir_valid;
   logic              ir_ready;
   logic [ADDR_W-1:0] pc;

   modport master (
      input  prog_we, prog_addr, prog_data, ir_ready,
      output ir_out, ir_valid, pc
   );

   modport slave (
      output prog_we, prog_addr, prog_data, ir_ready,
      input  ir_out, ir_valid, pc
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Program memory, PC and fetch FSM presenting 32-bit IRs with valid/ready.
// Optional conditional jumps are enabled with the BRANCH_EN macro.
//
// state     | meaning
// S_IDLE    | waiting for start, program writes allowed
// S_FETCH   | reading mem[pc] into ir_out
// S_PRESENT | ir_out valid, waiting for ir_ready
// S_HALT    | stopped on HALT opcode or end of program, writes allowed
module inst_fetch_unit #(
   parameter int PROG_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              sys_rst,
   inst_fetch_if.master      fb,
   input  logic              start,
   output logic              busy,
   output logic              halted
`ifdef BRANCH_EN
   ,
   input  logic              jmp_req,
   input  logic [2:0]        jmp_cond,
   input  logic [3:0]        flags,
   input  logic [ADDR_W-1:0] jmp_target
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_PRESENT = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(PROG_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);
   localparam logic [4:0]        OP_HALT   = 5'b11111;

   logic [31:0]       mem [PROG_DEPTH];
   logic [31:0]       mem_rd;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [31:0]       ir_q, ir_nxt;
   logic              valid_q, valid_nxt;
   logic              mem_we;
   logic              handshake;
   logic              jump_taken;
   logic              jump_ok;
   logic [ADDR_W-1:0] jump_pc;

   assign mem_rd    = mem[pc_q];
   assign handshake = valid_q & fb.ir_ready;

`ifdef BRANCH_EN
   logic cond_true;

   // flags = {sign, zero, overflow, carry}
   always_comb begin
      cond_true = 1'b0;
      case (jmp_cond)
         3'b000:  cond_true = 1'b1;
         3'b001:  cond_true = flags[2];
         3'b010:  cond_true = ~flags[2];
         3'b011:  cond_true = flags[3];
         3'b100:  cond_true = flags[0];
         3'b101:  cond_true = flags[1];
         default: cond_true = 1'b0;
      endcase
   end

   assign jump_taken = handshake & jmp_req & cond_true;
   assign jump_ok    = ({1'b0, jmp_target} < DEPTH_W);
   assign jump_pc    = jmp_target;
`else
   assign jump_taken = 1'b0;
   assign jump_ok    = 1'b0;
   assign jump_pc    = pc_q;
`endif

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         ir_q    <= ir_nxt;
         valid_q <= valid_nxt;
      end
   end

   // Memory is deliberately not reset; only the write strobe is blocked during reset.
   always_ff @(posedge clk) begin
      if (mem_we && !sys_rst)
         mem[fb.prog_addr] <= fb.prog_data;
   end

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      ir_nxt    = ir_q;
      valid_nxt = valid_q;
      mem_we    = 1'b0;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            mem_we = fb.prog_we && ({1'b0, fb.prog_addr} < DEPTH_W);
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = '0;
            end
         end
         S_FETCH: begin
            ir_nxt = mem_rd;
            if (mem_rd[31:27] == OP_HALT) begin
               state_nxt = S_HALT;
               valid_nxt = 1'b0;
            end else begin
               state_nxt = S_PRESENT;
               valid_nxt = 1'b1;
            end
         end
         S_PRESENT: begin
            if (handshake) begin
               valid_nxt = 1'b0;
               if (jump_taken) begin
                  if (jump_ok) begin
                     pc_nxt    = jump_pc;
                     state_nxt = S_FETCH;
                  end else begin
                     state_nxt = S_HALT;
                  end
               end else if (pc_q == LAST_ADDR) begin
                  state_nxt = S_HALT;
               end else begin
                  pc_nxt    = pc_q + 1'b1;
                  state_nxt = S_FETCH;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign fb.ir_out   = ir_q;
   assign fb.ir_valid = valid_q;
   assign fb.pc       = pc_q;
   assign busy        = (state_q == S_FETCH) || (state_q == S_PRESENT);
   assign halted      = (state_q == S_HALT);

endmodule
